// File: rtl/crypto_mul_arb.sv
// Round-robin arbiter in front of one shared A_W x B_W multiplier, 2-stage pipeline.
// Optional stall statistic enabled by defining CRYPTO_MUL_ARB_STAT_EN.
module crypto_mul_arb #(
  parameter int NREQ = 4,
  parameter int A_W  = 14,
  parameter int B_W  = 16,
  parameter int P_W  = A_W + B_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*A_W-1:0]      req_a,
  input  logic [NREQ*B_W-1:0]      req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [P_W-1:0]           res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [15:0]              stat_stall_cnt
);
  localparam int ID_W = $clog2(NREQ);

  logic            r_s1_valid;
  logic [A_W-1:0]  r_s1_a;
  logic [B_W-1:0]  r_s1_b;
  logic [ID_W-1:0] r_s1_id;
  logic            r_s2_valid;
  logic [P_W-1:0]  r_s2_data;
  logic [ID_W-1:0] r_s2_id;
  logic [ID_W-1:0] r_last_grant;

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_src;
  logic [NREQ-1:0] w_pick;
  logic [ID_W-1:0] w_pick_id;
  logic            w_found;
  logic [A_W-1:0]  w_sel_a;
  logic [B_W-1:0]  w_sel_b;
  logic [P_W-1:0]  w_prod;
  logic            w_s2_load;
  logic            w_s1_load;
  logic            w_xfer;

  // Handshake: a word moves on any edge where valid and ready are both high;
  // ready never depends on the same-cycle ready of another port except res_ready.
  assign w_s2_load = !r_s2_valid || res_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_xfer    = w_s1_load && (|req_valid);
  assign req_ready = w_s1_load ? w_pick : '0;

  // Requesters above last_grant get priority; wrap to the full vector otherwise.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (ID_W'(i) > r_last_grant);
    end
  end

  always_comb begin
    w_src     = (|(req_valid & w_mask)) ? (req_valid & w_mask) : req_valid;
    w_pick    = '0;
    w_pick_id = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_src[i] && !w_found) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_pick_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_sel_a = w_sel_a | req_a[i*A_W +: A_W];
        w_sel_b = w_sel_b | req_b[i*B_W +: B_W];
      end
    end
  end

  assign w_prod = P_W'(r_s1_a) * P_W'(r_s1_b);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_id      <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_data    <= '0;
      r_s2_id      <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_prod;
          r_s2_id   <= r_s1_id;
        end
      end
      if (w_s1_load) begin
        r_s1_valid <= w_xfer;
      end
      if (w_xfer) begin
        r_s1_a       <= w_sel_a;
        r_s1_b       <= w_sel_b;
        r_s1_id      <= w_pick_id;
        r_last_grant <= w_pick_id;
      end
    end
  end

  assign res_valid = r_s2_valid;
  assign res_data  = r_s2_data;
  assign res_id    = r_s2_id;

`ifdef CRYPTO_MUL_ARB_STAT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((|req_valid) && !w_xfer && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stat_stall_cnt = r_stall_cnt;
`else
  assign stat_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_crypto_mul_arb.sv
// Directed bench for crypto_mul_arb: single request, zero operand, fairness,
// backpressure, mid-operation reset and stall statistic.
module tb_crypto_mul_arb;
  localparam int NREQ = 4;
  localparam int A_W  = 14;
  localparam int B_W  = 16;
  localparam int P_W  = 30;

  logic                ap_clk;
  logic                ap_rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [P_W-1:0]      res_data;
  logic [1:0]          res_id;
  logic [15:0]         stat_stall_cnt;

  int n_checks;
  int n_fail;

  logic [31:0] prod_tab [NREQ];

  crypto_mul_arb #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_id         (res_id),
    .stat_stall_cnt (stat_stall_cnt)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic set_all();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, A_W'(i + 1), B_W'(i + 3));
    end
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    ap_rst_n  = 1'b0;
    tick();
    ap_rst_n  = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    prod_tab[0] = 32'd3;
    prod_tab[1] = 32'd8;
    prod_tab[2] = 32'd15;
    prod_tab[3] = 32'd24;

    // Reset state
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_stat", 32'(stat_stall_cnt), 32'd0);
    ap_rst_n = 1'b1;

    // Single request on requester 2, max operands
    tick();
    set_req(2, 14'h3FFF, 16'hFFFF);
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_lat1_valid", 32'(res_valid), 32'd0);
    tick();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'h3FFEC001);
    check("single_id", 32'(res_id), 32'd2);
    tick();
    check("single_drain", 32'(res_valid), 32'd0);

    // Zero operand on requester 0 (search starts at 3, wraps to 0)
    set_req(0, 14'h0000, 16'hABCD);
    #1;
    check("zero_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    check("zero_valid", 32'(res_valid), 32'd1);
    check("zero_data", 32'(res_data), 32'd0);
    check("zero_id", 32'(res_id), 32'd0);

    // Fairness from reset: all four valid, one grant per cycle
    reset_pulse();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) set_all();
      else req_valid = '0;
      #1;
      check("fair_ready", 32'(req_ready), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
      if (k >= 2) begin
        check("fair_valid", 32'(res_valid), 32'd1);
        check("fair_id", 32'(res_id), 32'((k - 2) % 4));
        check("fair_data", 32'(res_data), prod_tab[(k - 2) % 4]);
      end
      tick();
    end
    check("fair_drain", 32'(res_valid), 32'd0);

    // Backpressure: res_ready low for 5 cycles, last grant was 3
    res_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) res_ready = 1'b1;
      if (k < 7) set_all();
      else req_valid = '0;
      #1;
      case (k)
        0: check("bp_ready0", 32'(req_ready), 32'b0001);
        1: check("bp_ready1", 32'(req_ready), 32'b0010);
        5: check("bp_ready5", 32'(req_ready), 32'b0100);
        6: check("bp_ready6", 32'(req_ready), 32'b1000);
        default: check("bp_ready_stall", 32'(req_ready), 32'd0);
      endcase
      if (k < 2 || k == 9) begin
        check("bp_no_valid", 32'(res_valid), 32'd0);
      end else begin
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_id", 32'(res_id), (k < 6) ? 32'd0 : 32'(k - 5));
        check("bp_data", 32'(res_data), (k < 6) ? prod_tab[0] : prod_tab[k - 5]);
      end
      tick();
    end

    // Mid-operation reset with S1 and S2 full
    res_ready = 1'b0;
    set_all();
    tick();
    tick();
    check("mid_full_valid", 32'(res_valid), 32'd1);
    req_valid = '0;
    ap_rst_n  = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_data", 32'(res_data), 32'd0);
    tick();
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    set_req(0, 14'd7, 16'd9);
    set_req(3, 14'd5, 16'd5);
    #1;
    check("mid_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    check("mid_no_stale", 32'(res_valid), 32'd0);
    tick();
    check("mid_res_valid", 32'(res_valid), 32'd1);
    check("mid_res_id", 32'(res_id), 32'd0);
    check("mid_res_data", 32'(res_data), 32'd63);

    // Stall statistic: two transfers, then ten stalled cycles
    reset_pulse();
    res_ready = 1'b0;
    set_req(0, 14'd1, 16'd1);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check("stat_stalled_ready", 32'(req_ready), 32'd0);
      tick();
    end
`ifdef CRYPTO_MUL_ARB_STAT_EN
    check("stat_ten", 32'(stat_stall_cnt), 32'd10);
    for (int k = 0; k < 65530; k++) begin
      @(posedge ap_clk);
    end
    #1;
    check("stat_saturate", 32'(stat_stall_cnt), 32'hFFFF);
`else
    check("stat_tied_zero", 32'(stat_stall_cnt), 32'd0);
`endif
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    check("final_drain", 32'(res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/crypto_mul_arb.md
CRYPTO_MUL_ARB -- requirements
Module: crypto_mul_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter A_W, default 14, meaning operand A width (unsigned).
REQ-003 SHALL have parameter B_W, default 16, meaning operand B width (unsigned).
REQ-004 SHALL have parameter P_W, default 30, meaning product width, fixed at A_W+B_W.
REQ-005 SHALL have port ap_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, NREQ, meaning per-requester operand valid.
REQ-008 SHALL have port req_ready, output, NREQ, meaning per-requester grant/accept.
REQ-009 SHALL have port req_a, input, NREQ*A_W, meaning packed operand A, requester i at bits [i*A_W +: A_W].
REQ-010 SHALL have port req_b, input, NREQ*B_W, meaning packed operand B, requester i at bits [i*B_W +: B_W].
REQ-011 SHALL have port res_valid, output, 1, meaning result valid.
REQ-012 SHALL have port res_ready, input, 1, meaning downstream accepts result.
REQ-013 SHALL have port res_data, output, P_W, meaning unsigned product A*B.
REQ-014 SHALL have port res_id, output, clog2(NREQ), meaning index of the requester that issued the result.
REQ-015 SHALL have port stat_stall_cnt, output, 16, meaning stall statistic (see Configuration).

Function
REQ-016 SHALL contain exactly one internal combinational unsigned A_W x B_W multiplier, shared by all requesters.
REQ-017 SHALL use a 2-stage pipeline: S1 holds granted operands plus id plus valid bit; S2 holds registered product plus id plus valid bit.
REQ-018 SHALL transfer a request on requester i when req_valid[i] and req_ready[i] are both 1 on a clock edge.
REQ-019 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1 (one-hot or zero).
REQ-020 SHALL grant only when S1 can load: S1 empty, or S1 advancing into S2 in the same cycle.
REQ-021 SHALL advance S1 into S2 when S2 is empty or res_ready=1; res_valid SHALL equal the S2 valid bit.
REQ-022 SHALL use round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on an actual transfer.
REQ-023 SHALL provide latency of exactly 2 cycles from transfer edge to res_valid=1 with no backpressure; throughput 1 result/cycle.
REQ-024 SHALL hold res_data/res_id stable while res_valid=1 and res_ready=0; no result is ever dropped or duplicated.
REQ-025 SHALL, with S2 stalled and S1 full, deassert all req_ready; the pipeline SHALL resume on the first res_ready=1 with no bubble.
REQ-026 SHALL compute full-width product; max inputs (2^14-1)*(2^16-1)=0x3FFEC001 with no truncation.
REQ-027 SHALL, when req_valid drops without transfer, leave last_grant unchanged (no grant-while-absent).

Reset
REQ-028 SHALL, on ap_rst_n=0, asynchronously clear S1/S2 valid bits, res_valid=0, req_ready=0 (combinational from cleared state), res_data=0, res_id=0, stat_stall_cnt=0, last_grant=NREQ-1 (requester 0 first).
REQ-029 SHALL discard in-flight S1/S2 contents on mid-operation reset; first grant after release follows REQ-028 priority.

Configuration
REQ-030 SHALL, with macro CRYPTO_MUL_ARB_STAT_EN defined, count cycles where |req_valid=1 and no transfer occurs, saturating at 0xFFFF.
REQ-031 SHALL, without CRYPTO_MUL_ARB_STAT_EN, tie stat_stall_cnt to 0 and synthesize no counter logic; port list unchanged.

Verification
REQ-032 SHALL cover single request: req 2 with A=0x3FFF, B=0xFFFF, res_ready=1 -> res_valid 2 cycles later, res_data=0x3FFEC001, res_id=2.
REQ-033 SHALL cover all-request fairness: all 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,... one per cycle, no gaps.
REQ-034 SHALL cover backpressure: res_ready=0 for 5 cycles with 4 requesters valid -> exactly 2 transfers then req_ready=0; results emerge in order on release, none lost.
REQ-035 SHALL cover mid-op reset: reset asserted with S1,S2 full -> res_valid=0 immediately; after release req 0 granted first when 0 and 3 valid.
REQ-036 SHALL cover stat counter: with CRYPTO_MUL_ARB_STAT_EN, 10 stalled cycles -> stat_stall_cnt=10; saturates at 0xFFFF; without macro reads 0.
REQ-037 SHALL cover zero operand: A=0, B=0xABCD -> res_data=0.
